// File: rtl/gpr_snapshot_pkg.sv
// Shared types and sizes for the GPR snapshot serializer.
package gpr_snapshot_pkg;

    localparam int unsigned NUM_GPRS        = 32;
    localparam int unsigned GPR_INDEX_WIDTH = 5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } snapshot_state_t;

    typedef logic [NUM_GPRS-1:0] gpr_mask_t;

endpackage

// File: rtl/gpr_snapshot_serializer_lowest_set_bit_finder.sv
// Combinational lowest-set-bit index finder with valid and single-bit flags.
module lowest_set_bit_finder
    import gpr_snapshot_pkg::*;
(
    input  gpr_mask_t                   i_mask,
    output logic [GPR_INDEX_WIDTH-1:0]  o_index_c,
    output logic                        o_valid_c,
    output logic                        o_only_one_set_c
);

    // Scan from the top so the lowest set bit is the final assignment.
    always_comb begin
        o_index_c = '0;
        for (int i = NUM_GPRS - 1; i >= 0; i--) begin
            if (i_mask[i]) begin
                o_index_c = GPR_INDEX_WIDTH'(i);
            end
        end
        o_valid_c        = |i_mask;
        o_only_one_set_c = o_valid_c && ((i_mask & (i_mask - gpr_mask_t'(1))) == '0);
    end

endmodule

// File: rtl/gpr_snapshot_serializer.sv
// Captures the shadow GPR file on request and streams selected registers over valid/ready.
// Optional build macro GPR_SNAPSHOT_SKIP_ZERO_EN drops zero-valued registers from the capture mask.
module gpr_snapshot_serializer
    import gpr_snapshot_pkg::*;
#(
    parameter int unsigned REGISTER_WIDTH   = 128,
    parameter int unsigned DROP_COUNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [REGISTER_WIDTH-1:0]    registers_in [NUM_GPRS],
    input  logic                         snapshot_req,
    input  logic [NUM_GPRS-1:0]          reg_mask,
    output logic                         busy,
    output logic                         snapshot_drop,
    output logic [DROP_COUNT_WIDTH-1:0]  dropped_count,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [REGISTER_WIDTH-1:0]    m_data,
    output logic [GPR_INDEX_WIDTH-1:0]   m_index,
    output logic                         m_last
);

    snapshot_state_t              r_state;
    snapshot_state_t              w_state_next;
    gpr_mask_t                    r_mask;
    gpr_mask_t                    w_mask_next;
    gpr_mask_t                    w_eff_mask;
    logic [REGISTER_WIDTH-1:0]    r_buf [NUM_GPRS];
    logic                         w_capture;
    logic                         w_drop;
    logic                         r_busy;
    logic                         r_drop;
    logic [DROP_COUNT_WIDTH-1:0]  r_cnt;
    logic [REGISTER_WIDTH-1:0]    r_data;
    logic [REGISTER_WIDTH-1:0]    w_data_next;
    logic [GPR_INDEX_WIDTH-1:0]   r_index;
    logic                         r_last;
    logic [GPR_INDEX_WIDTH-1:0]   w_idx;
    logic                         w_idx_valid;
    logic                         w_only_one;

    // Effective selection applied at capture time.
    always_comb begin
        w_eff_mask = reg_mask;
`ifdef GPR_SNAPSHOT_SKIP_ZERO_EN
        for (int i = 0; i < NUM_GPRS; i++) begin
            w_eff_mask[i] = reg_mask[i] && (registers_in[i] != '0);
        end
`endif
    end

    // Next-state logic; a request seen in SEND is always rejected.
    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_capture    = 1'b0;
        w_drop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (snapshot_req && (w_eff_mask != '0)) begin
                    w_capture    = 1'b1;
                    w_mask_next  = w_eff_mask;
                    w_state_next = SEND;
                end
            end
            SEND: begin
                w_drop = snapshot_req;
                if (m_ready) begin
                    w_mask_next = r_mask & (r_mask - gpr_mask_t'(1));
                    if (r_last) begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are precomputed from the mask the stream will hold next cycle.
    lowest_set_bit_finder u_finder (
        .i_mask           (w_mask_next),
        .o_index_c        (w_idx),
        .o_valid_c        (w_idx_valid),
        .o_only_one_set_c (w_only_one)
    );

    always_comb begin
        w_data_next = '0;
        if (w_idx_valid) begin
            w_data_next = w_capture ? registers_in[w_idx] : r_buf[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_index <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
            r_busy  <= (w_state_next == SEND);
            r_drop  <= w_drop;
            if (w_drop && (r_cnt != '1)) begin
                r_cnt <= r_cnt + DROP_COUNT_WIDTH'(1);
            end
            r_data  <= w_data_next;
            r_index <= w_idx_valid ? w_idx : '0;
            r_last  <= w_idx_valid && w_only_one;
        end
    end

    // Capture buffer isolates the stream from live writebacks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPRS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < NUM_GPRS; i++) begin
                r_buf[i] <= registers_in[i];
            end
        end
    end

    assign busy          = r_busy;
    assign m_valid       = r_busy;
    assign snapshot_drop = r_drop;
    assign dropped_count = r_cnt;
    assign m_data        = r_data;
    assign m_index       = r_index;
    assign m_last        = r_last;

endmodule

// File: tb/tb_gpr_snapshot_serializer.sv
// Self-checking bench: scoreboard of expected beats plus a vector table and directed corner cases.
module tb_gpr_snapshot_serializer;
    import gpr_snapshot_pkg::*;

    localparam int unsigned RW = 128;
    localparam int unsigned DW = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [RW-1:0]  regs [NUM_GPRS];
    logic           snapshot_req;
    logic [31:0]    reg_mask;
    logic           m_ready;
    logic           busy, snapshot_drop, m_valid, m_last;
    logic [DW-1:0]  dropped_count;
    logic [RW-1:0]  m_data;
    logic [4:0]     m_index;

    logic           s_req;
    logic           s_busy, s_drop, s_valid, s_last;
    logic [2:0]     s_cnt;
    logic [RW-1:0]  s_data;
    logic [4:0]     s_index;

    typedef struct {
        logic [4:0]    idx;
        logic [RW-1:0] data;
        logic          last;
    } beat_t;

    typedef struct {
        logic [31:0] mask;
        bit          rnd;
        int          exp_beats;
        int          exp_first;
    } vec_t;

    beat_t sb [$];
    int    total = 0;
    int    bad = 0;
    int    n_beats = 0;

    gpr_snapshot_serializer #(.REGISTER_WIDTH(RW), .DROP_COUNT_WIDTH(DW)) u_dut (
        .clk(clk), .rst_n(rst_n), .registers_in(regs), .snapshot_req(snapshot_req),
        .reg_mask(reg_mask), .busy(busy), .snapshot_drop(snapshot_drop),
        .dropped_count(dropped_count), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_index(m_index), .m_last(m_last)
    );

    // Narrow counter instance so saturation is reachable in a few requests.
    gpr_snapshot_serializer #(.REGISTER_WIDTH(RW), .DROP_COUNT_WIDTH(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .registers_in(regs), .snapshot_req(s_req),
        .reg_mask(32'hFFFF_FFFF), .busy(s_busy), .snapshot_drop(s_drop),
        .dropped_count(s_cnt), .m_valid(s_valid), .m_ready(1'b0),
        .m_data(s_data), .m_index(s_index), .m_last(s_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_regs();
        for (int i = 0; i < NUM_GPRS; i++) begin
            regs[i] = {32'(i + 1), $urandom, $urandom, $urandom};
        end
    endtask

    task automatic push_expected(input logic [31:0] mask);
        int ids [$];
        for (int i = 0; i < NUM_GPRS; i++) begin
            bit take;
            take = mask[i];
`ifdef GPR_SNAPSHOT_SKIP_ZERO_EN
            if (regs[i] == '0) take = 1'b0;
`endif
            if (take) ids.push_back(i);
        end
        foreach (ids[k]) begin
            beat_t b;
            b.idx  = 5'(ids[k]);
            b.data = regs[ids[k]];
            b.last = (k == ids.size() - 1);
            sb.push_back(b);
        end
    endtask

    task automatic request(input logic [31:0] mask, input bit accept);
        reg_mask     = mask;
        snapshot_req = 1'b1;
        if (accept) push_expected(mask);
        tick();
        snapshot_req = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        m_ready = 1'b1;
        total++;
        if (busy) begin
            bad++;
            $display("FAIL wait_idle: busy=1 after %0d cycles, want 0", budget);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},  RW'(busy), RW'(0));
        chk({tag, "_drop"},  RW'(snapshot_drop), RW'(0));
        chk({tag, "_count"}, RW'(dropped_count), RW'(0));
        chk({tag, "_valid"}, RW'(m_valid), RW'(0));
        chk({tag, "_data"},  m_data, RW'(0));
        chk({tag, "_index"}, RW'(m_index), RW'(0));
        chk({tag, "_last"},  RW'(m_last), RW'(0));
    endtask

    // Every accepted beat is matched against the scoreboard in order.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && m_valid && m_ready) begin
            n_beats++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL extra_beat: got index %0d, want no beat", m_index);
            end else begin
                e = sb.pop_front();
                chk("beat_index", RW'(m_index), RW'(e.idx));
                chk("beat_data", m_data, e.data);
                chk("beat_last", RW'(m_last), RW'(e.last));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs [4];
        vecs[0] = '{32'hFFFF_FFFF, 1'b1, 32, 0};
        vecs[1] = '{32'h0001_0000, 1'b1, 1, 16};
        vecs[2] = '{32'hAAAA_5555, 1'b1, 16, 0};
        vecs[3] = '{32'h8000_0000, 1'b0, 1, 31};

        rst_n = 1'b0; snapshot_req = 1'b0; reg_mask = '0; m_ready = 1'b1; s_req = 1'b0;
        set_regs();
        repeat (3) tick();
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Two-beat stream with back-to-back handshakes.
        regs[1] = 128'hA; regs[2] = 128'hB;
        request(32'h0000_0006, 1'b1);
        chk("t1_valid", RW'(m_valid), RW'(1));
        chk("t1_busy", RW'(busy), RW'(1));
        chk("t1_idx0", RW'(m_index), RW'(1));
        chk("t1_data0", m_data, RW'(128'hA));
        chk("t1_last0", RW'(m_last), RW'(0));
        tick();
        chk("t1_idx1", RW'(m_index), RW'(2));
        chk("t1_data1", m_data, RW'(128'hB));
        chk("t1_last1", RW'(m_last), RW'(1));
        tick();
        chk("t1_busy_end", RW'(busy), RW'(0));
        chk("t1_valid_end", RW'(m_valid), RW'(0));

        // Backpressure while the live register keeps changing.
        set_regs();
        regs[0] = 128'h1234;
        m_ready = 1'b0;
        request(32'h8000_0001, 1'b1);
        for (int c = 0; c < 5; c++) begin
            chk("t2_hold_valid", RW'(m_valid), RW'(1));
            chk("t2_hold_index", RW'(m_index), RW'(0));
            chk("t2_hold_data", m_data, RW'(128'h1234));
            chk("t2_hold_last", RW'(m_last), RW'(0));
            regs[0] = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        m_ready = 1'b1;
        tick();
        chk("t2_idx31", RW'(m_index), RW'(31));
        chk("t2_last31", RW'(m_last), RW'(1));
        tick();
        chk("t2_idle", RW'(busy), RW'(0));

        // Saturating counter on the narrow instance.
        s_req = 1'b1;
        tick();
        s_req = 1'b0;
        chk("sat_busy", RW'(s_busy), RW'(1));
        chk("sat_first_index", RW'(s_index), RW'(0));
        chk("sat_first_last", RW'(s_last), RW'(0));
        chk("sat_valid", RW'(s_valid), RW'(1));
        for (int d = 1; d <= 9; d++) begin
            s_req = 1'b1;
            tick();
            s_req = 1'b0;
            chk("sat_drop", RW'(s_drop), RW'(1));
            chk("sat_count", RW'(s_cnt), RW'((d > 7) ? 7 : d));
        end
        chk("sat_data_held", RW'(s_data != '0), RW'(1));

        // Requests while busy are rejected and leave the stream intact.
        set_regs();
        m_ready = 1'b0;
        request(32'hFFFF_FFFF, 1'b1);
        tick();
        for (int r = 0; r < 3; r++) begin
            request(32'h0000_0005, 1'b0);
            chk("t3_drop", RW'(snapshot_drop), RW'(1));
            chk("t3_index", RW'(m_index), RW'(0));
            tick();
            chk("t3_drop_clear", RW'(snapshot_drop), RW'(0));
        end
        chk("t3_count", RW'(dropped_count), RW'(3));
        chk("t3_data", m_data, regs[0]);
        wait_idle(1'b0, 100);
        chk("t3_sb_empty", RW'(sb.size()), RW'(0));

        // Empty mask is ignored silently.
        request(32'h0, 1'b0);
        chk("t4_busy", RW'(busy), RW'(0));
        chk("t4_valid", RW'(m_valid), RW'(0));
        chk("t4_drop", RW'(snapshot_drop), RW'(0));

        // Request coinciding with the final handshake is dropped.
        m_ready = 1'b1;
        request(32'h0000_0003, 1'b1);
        tick();
        chk("t4_last_seen", RW'(m_last), RW'(1));
        request(32'h0000_000F, 1'b0);
        chk("t4_last_drop", RW'(snapshot_drop), RW'(1));
        chk("t4_last_busy", RW'(busy), RW'(0));
        chk("t4_last_valid", RW'(m_valid), RW'(0));
        chk("t4_last_count", RW'(dropped_count), RW'(4));
        tick();

        // Vector table with random backpressure.
        for (int v = 0; v < 4; v++) begin
            set_regs();
            n_beats = 0;
            m_ready = vecs[v].rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            request(vecs[v].mask, 1'b1);
            chk("vec_first_index", RW'(m_index), RW'(vecs[v].exp_first));
            chk("vec_valid", RW'(m_valid), RW'(1));
            wait_idle(vecs[v].rnd, 400);
            chk("vec_beats", RW'(n_beats), RW'(vecs[v].exp_beats));
            chk("vec_sb_empty", RW'(sb.size()), RW'(0));
        end

        // Reset during the third beat aborts the stream.
        set_regs();
        m_ready = 1'b1;
        request(32'h0000_03FF, 1'b1);
        tick();
        tick();
        chk("t6_beat3_index", RW'(m_index), RW'(2));
        rst_n = 1'b0;
        tick();
        chk_reset_outputs("t6_rst");
        sb.delete();
        rst_n = 1'b1;
        tick();
        request(32'h0000_0030, 1'b1);
        chk("t6_restart_index", RW'(m_index), RW'(4));
        wait_idle(1'b0, 50);
        chk("t6_sb_empty", RW'(sb.size()), RW'(0));

        // Zero-valued registers in the selection.
        set_regs();
        regs[0] = '0;
        regs[2] = '0;
        n_beats = 0;
        request(32'h0000_0007, 1'b1);
`ifdef GPR_SNAPSHOT_SKIP_ZERO_EN
        chk("t6_zero_index", RW'(m_index), RW'(1));
        chk("t6_zero_last", RW'(m_last), RW'(1));
`else
        chk("t6_zero_index", RW'(m_index), RW'(0));
        chk("t6_zero_last", RW'(m_last), RW'(0));
`endif
        wait_idle(1'b0, 50);
`ifdef GPR_SNAPSHOT_SKIP_ZERO_EN
        chk("t6_zero_beats", RW'(n_beats), RW'(1));
`else
        chk("t6_zero_beats", RW'(n_beats), RW'(3));
`endif
        chk("t6_zero_sb_empty", RW'(sb.size()), RW'(0));

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
